sd_sector_writer: RTL
=====================

SD_SECTOR_WRITER -- requirements
Module: sd_sector_writer

Interface
REQ-001 The block SHALL have parameter SECTOR_BYTES, default 512, bytes per sector; only 512 is supported.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000000, maximum clk cycles spent in any wait state.
REQ-003 The block SHALL have port clk, input, 1, single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port buf_we, input, 1, bus write strobe into the sector buffer.
REQ-006 The block SHALL have port buf_addr, input, 9, byte index into the buffer.
REQ-007 The block SHALL have port buf_wdata, input, 8, byte written into the buffer.
REQ-008 The block SHALL have port sec_addr_we, input, 1, strobe that loads the sector address.
REQ-009 The block SHALL have port sec_addr_wdata, input, 32, sector address value.
REQ-010 The block SHALL have port start, input, 1, single-cycle request to write the buffer to the card.
REQ-011 The block SHALL have port busy, output, 1, high while a transfer is in progress.
REQ-012 The block SHALL have port done, output, 1, sticky flag for a successful transfer.
REQ-013 The block SHALL have port error, output, 1, sticky flag for a timeout.
REQ-014 The block SHALL have port sd_wr, output, 1, write command to the SD controller.
REQ-015 The block SHALL have port sd_address, output, 32, sector address driven to the SD controller.
REQ-016 The block SHALL have port sd_din, output, 8, data byte offered to the SD controller.
REQ-017 The block SHALL have port sd_ready, input, 1, SD controller idle/ready level.
REQ-018 The block SHALL have port sd_ready_for_next_byte, input, 1, SD controller byte-consumed indication.

Function
REQ-019 The sector buffer SHALL be 512x8 block RAM with a 1-cycle synchronous read.
REQ-020 When buf_we is high and busy is low, the block SHALL write buffer[buf_addr] <= buf_wdata; when busy is high, buf_we SHALL be ignored.
REQ-021 When sec_addr_we is high and busy is low, the block SHALL load sd_address from sec_addr_wdata; when busy is high, sec_addr_we SHALL be ignored.
REQ-022 The FSM SHALL have states IDLE, ISSUE, ACK, STREAM, FINISH.
REQ-023 In IDLE, when start is high, the block SHALL clear done and error, set the byte index to 0, and go to ISSUE; busy SHALL rise on the next cycle.
REQ-024 In ISSUE, while sd_ready is high, the block SHALL assert sd_wr for exactly one cycle and go to ACK.
REQ-025 In ACK, the block SHALL hold sd_wr low and wait for sd_ready to be 0, then go to STREAM.
REQ-026 sd_din SHALL equal buffer[index], registered, and SHALL be valid within 2 cycles of an index change.
REQ-027 The block SHALL detect a byte acceptance as a rising edge of sd_ready_for_next_byte: the input is registered once and an edge is counted as current high while the registered copy is low.
REQ-028 In STREAM, each detected edge SHALL increment the 10-bit index; when the index reaches 512, the block SHALL go to FINISH.
REQ-029 Rising edges of sd_ready_for_next_byte outside STREAM, or after the index reaches 512, SHALL be ignored.
REQ-030 In FINISH, when sd_ready returns to 1, the block SHALL set done, clear busy, and return to IDLE.
REQ-031 A timeout counter SHALL reset on every state change and on every counted edge; if it reaches TIMEOUT_CYCLES in ISSUE, ACK, STREAM or FINISH, the block SHALL set error, clear busy, deassert sd_wr, and go to IDLE.
REQ-032 A start pulse received while busy is high SHALL be ignored, with no effect on the flags or the index.
REQ-033 If start and buf_we are high in the same IDLE cycle, the buffer write SHALL complete, and that byte SHALL be the one transmitted.
REQ-034 Within the same transfer, done and error SHALL NOT both be high.

Reset
REQ-035 On reset high at a clk edge, the block SHALL return to IDLE.
REQ-036 Reset SHALL force busy=0, done=0, error=0, sd_wr=0, sd_din=0, sd_address=0, index=0, timeout=0, and the edge register=0.
REQ-037 Reset SHALL NOT clear buffer contents.
REQ-038 A reset during a transfer SHALL abort it immediately, with no further sd_wr pulse.

Verification
REQ-039 Normal write: fill buffer[i]=i[7:0], sector 0x00000010, start; the controller model drops sd_ready, gives 512 edges, then raises sd_ready -> exactly one sd_wr pulse, sd_din sequence 0x00..0xFF twice, done=1, busy=0, error=0.
REQ-040 Edge behaviour: hold sd_ready_for_next_byte high for 20 cycles per byte -> each byte counted once, index exactly 512, and 3 extra edges in FINISH are ignored.
REQ-041 Timeout: with TIMEOUT_CYCLES=100, start while sd_ready stays 0 -> after 100 cycles error=1, busy=0, sd_wr never asserted.
REQ-042 Busy lockout: issue buf_we to addr 5 with data 0xAA and sec_addr_we=0xFFFF during STREAM, plus a second start -> buffer[5] and sd_address are unchanged, and exactly 512 bytes are sent.
REQ-043 Reset mid-stream: assert reset after 100 edges -> the next cycle shows busy=0, done=0, sd_wr=0; a new start then sends all 512 bytes starting from index 0.
REQ-044 Simultaneous events: start together with buf_we to addr 0 with data 0x5C -> the first sd_din is 0x5C.

Source files
------------

// File: rtl/sd_sector_writer_if.sv
// Host-bus and SD-controller signals of the sector writer, grouped as one bundle.
// The master side drives the bus strobes and controller status; the slave is the writer.
interface sd_sector_writer_if;
  logic        buf_we;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic        sec_addr_we;
  logic [31:0] sec_addr_wdata;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic        sd_wr;
  logic [31:0] sd_address;
  logic [7:0]  sd_din;
  logic        sd_ready;
  logic        sd_ready_for_next_byte;

  modport master (
    output buf_we, buf_addr, buf_wdata, sec_addr_we, sec_addr_wdata, start,
           sd_ready, sd_ready_for_next_byte,
    input  busy, done, error, sd_wr, sd_address, sd_din
  );

  modport slave (
    input  buf_we, buf_addr, buf_wdata, sec_addr_we, sec_addr_wdata, start,
           sd_ready, sd_ready_for_next_byte,
    output busy, done, error, sd_wr, sd_address, sd_din
  );
endinterface

// File: rtl/sd_sector_writer.sv
// Streams a 512-byte buffer to an SD controller: one write command, then one byte per
// rising edge of sd_ready_for_next_byte, with a per-state timeout.
module sd_sector_writer #(
  parameter int unsigned SECTOR_BYTES   = 512,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input logic               clk,
  input logic               reset,
  sd_sector_writer_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] ACK    = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [9:0]  END_IDX  = 10'(SECTOR_BYTES);
  localparam logic [9:0]  LAST_IDX = 10'(SECTOR_BYTES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [7:0]  buf_mem [SECTOR_BYTES];
  logic [2:0]  state_q, state_d;
  logic [9:0]  index_q, index_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        sd_wr_q, sd_wr_d;
  logic [7:0]  din_q;
  logic        rfnb_q;
  logic        rfnb_rise;
  logic        progress;

  assign rfnb_rise = bus.sd_ready_for_next_byte & ~rfnb_q;

  // Buffer contents survive reset; writes are locked out for the whole transfer.
  always_ff @(posedge clk) begin
    if (bus.buf_we && !busy_q) begin
      buf_mem[bus.buf_addr] <= bus.buf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      din_q <= '0;
    end else begin
      din_q <= buf_mem[index_q[8:0]];
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    tmo_d    = tmo_q + 32'd1;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    error_d  = error_q;
    sd_wr_d  = 1'b0;
    progress = 1'b0;

    if (bus.sec_addr_we && !busy_q) begin
      addr_d = bus.sec_addr_wdata;
    end

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (bus.start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          index_d = '0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.sd_ready) begin
          sd_wr_d = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!bus.sd_ready) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (rfnb_rise && index_q != END_IDX) begin
          index_d  = index_q + 10'd1;
          progress = 1'b1;
          if (index_q == LAST_IDX) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        if (bus.sd_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      progress = 1'b1;
    end
    if (progress) begin
      tmo_d = '0;
    end

    // A stalled wait state ends the transfer with error instead of done.
    if (state_q != IDLE && !progress && tmo_q == TMO_LAST) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
      sd_wr_d = 1'b0;
      state_d = IDLE;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      sd_wr_q <= 1'b0;
      rfnb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      sd_wr_q <= sd_wr_d;
      rfnb_q  <= bus.sd_ready_for_next_byte;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.sd_wr      = sd_wr_q;
  assign bus.sd_address = addr_q;
  assign bus.sd_din     = din_q;

endmodule
